keypad_scanner: RTL and testbench

Matrix-keypad scanner for the front-panel hex keypad; it is the input-side counterpart of the multiplexed 7-segment display driver. It drives one keypad row low at a time, samples the column lines through a synchronizer, debounces presses and releases, and holds a key code with a valid flag until the CPU-side logic acknowledges it. It sits between the keypad pins and the monitor's keyboard port.

---
 rtl/kbd_pkg.sv | 27 ++
 rtl/keypad_scanner_if.sv | 20 ++
 rtl/col_sync.sv | 27 ++
 rtl/keypad_scanner.sv | 156 +++++++++++++++
 tb/tb_keypad_scanner.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/kbd_pkg.sv
// Shared types, default parameters and helpers for the front-panel keypad scanner.
package kbd_pkg;

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    CONFIRM = 2'd1,
    PRESSED = 2'd2
  } state_e;

  localparam int ROWS_DEF     = 4;
  localparam int COLS_DEF     = 4;
  localparam int SCAN_DIV_DEF = 4096;
  localparam int DEBOUNCE_DEF = 8;
  localparam int CW_DEF       = $clog2(ROWS_DEF * COLS_DEF);

  // Widest column bus the priority encoder accepts; unused upper bits are padded high.
  localparam int MAX_COLS = 32;

  // Index of the lowest column pulled low (0 when none is low).
  function automatic int unsigned lowest_low(input logic [MAX_COLS-1:0] pat_n);
    lowest_low = 0;
    for (int i = MAX_COLS - 1; i >= 0; i--) begin
      if (!pat_n[i]) lowest_low = unsigned'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// CPU-side key port of the keypad scanner: key code, status flags and read acknowledge.
interface keypad_scanner_if #(
  parameter int CW = kbd_pkg::CW_DEF
);
  logic [CW-1:0] key_code;
  logic          key_valid;
  logic          key_rd;
  logic          overrun;
  logic          key_down;

  modport master (
    output key_code, key_valid, overrun, key_down,
    input  key_rd
  );

  modport slave (
    input  key_code, key_valid, overrun, key_down,
    output key_rd
  );
endinterface

// File: rtl/col_sync.sv
// Two-flop synchronizer for the asynchronous column sense lines; idles high (no key).
module col_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      // NOTE: non-blocking so the second stage takes the first stage's pre-edge value.
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: walks the rows, debounces presses/releases and holds
// the accepted key code with valid/overrun flags until the CPU acknowledges it.
module keypad_scanner
  import kbd_pkg::*;
#(
  parameter int ROWS     = ROWS_DEF,
  parameter int COLS     = COLS_DEF,
  parameter int SCAN_DIV = SCAN_DIV_DEF,
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ROWS-1:0]   row_n,
  input  logic [COLS-1:0]   col_n,
  keypad_scanner_if.master  kbd
);

  localparam int CW = $clog2(ROWS * COLS);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int TW = $clog2(SCAN_DIV);
  localparam int MW = $clog2(DEBOUNCE + 2);

  logic [COLS-1:0] col_s;

  state_e          state_q, state_d;
  logic [RW-1:0]   row_q, row_d, row_next;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [COLS-1:0] pat_q, pat_d;
  logic [MW-1:0]   match_q, match_d;
  logic [MW-1:0]   rel_q, rel_d;
  logic [CW-1:0]   code_q, code_d, cand_code;
  logic            valid_q, valid_d;
  logic            ovr_q, ovr_d;
  logic            tick;
  logic            accept;
  logic [MAX_COLS-1:0] pat_pad;

  col_sync #(.W(COLS)) u_col_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (col_n),
    .q     (col_s)
  );

  assign tick     = (cnt_q == TW'(SCAN_DIV - 1));
  assign row_next = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
  assign cnt_d    = tick ? '0 : cnt_q + 1'b1;

  always_comb begin
    pat_pad            = '1;
    pat_pad[COLS-1:0]  = pat_q;
    cand_code          = CW'((32'(row_q) * 32'(COLS)) + lowest_low(pat_pad));
  end

  // Scan / debounce FSM; the row only moves on a tick that did not hold a key.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    state_d = state_q;
    row_d   = row_q;
    pat_d   = pat_q;
    match_d = match_q;
    rel_d   = rel_q;
    accept  = 1'b0;
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (!(&col_s)) begin
            pat_d   = col_s;
            match_d = MW'(1);
            state_d = CONFIRM;
          end else begin
            row_d = row_next;
          end
        end
        CONFIRM: begin
          if (col_s != pat_q) begin
            row_d   = row_next;
            state_d = SCAN;
          end else if (match_q == MW'(DEBOUNCE)) begin
            accept  = 1'b1;
            rel_d   = '0;
            state_d = PRESSED;
          end else begin
            match_d = match_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!(&col_s)) begin
            rel_d = '0;
          end else if (rel_q == MW'(DEBOUNCE - 1)) begin
            rel_d   = '0;
            row_d   = row_next;
            state_d = SCAN;
          end else begin
            rel_d = rel_q + 1'b1;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // Acknowledge has priority over overrun; an accept during key_rd replaces the code.
  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (kbd.key_rd) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (accept) begin
      if (!valid_q || kbd.key_rd) begin
        code_d  = cand_code;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SCAN;
      row_q   <= '0;
      cnt_q   <= '0;
      pat_q   <= '1;
      match_q <= '0;
      rel_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      match_q <= match_d;
      rel_q   <= rel_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    row_n        = '1;
    row_n[row_q] = 1'b0;
  end

  assign kbd.key_code  = code_q;
  assign kbd.key_valid = valid_q;
  assign kbd.overrun   = ovr_q;
  assign kbd.key_down  = (state_q == PRESSED);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a 4x4 switch-matrix model (SCAN_DIV=4, DEBOUNCE=3).
module tb_keypad_scanner;
  import kbd_pkg::*;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int BUDGET = 300;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [ROWS-1:0] row_n;
  logic [COLS-1:0] col_n;
  logic [15:0]     keys;

  int n_vec = 0;
  int n_err = 0;

  keypad_scanner_if #(.CW(4)) kbd_bus ();

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4), .DEBOUNCE(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .row_n (row_n),
    .col_n (col_n),
    .kbd   (kbd_bus)
  );

  always #5 clk = ~clk;

  // Switch matrix: a closed key pulls its column low while its row is driven.
  always_comb begin
    col_n = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys[r*COLS+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  typedef struct {
    int          row;
    int          col;
    logic [3:0]  exp_code;
    logic [3:0]  exp_row_n;
  } key_vec_t;

  key_vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Closes key (r,c) just before row r becomes driven; returns at the negedge after that edge.
  task automatic press_at_entry(input int r, input int c, input string name);
    int n = 0;
    while (row_n[r] == 1'b0 && n < BUDGET) begin @(negedge clk); n++; end
    keys[r*COLS+c] = 1'b1;
    while (row_n[r] != 1'b0 && n < BUDGET) begin @(negedge clk); n++; end
    check({name, "_row_reached"}, 32'(row_n[r]), 32'(0));
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (kbd_bus.key_valid !== 1'b1 && n < BUDGET) begin @(negedge clk); n++; end
    check({name, "_valid"}, 32'(kbd_bus.key_valid), 32'(1));
  endtask

  task automatic wait_down(input logic lvl, input string name);
    int n = 0;
    while (kbd_bus.key_down !== lvl && n < BUDGET) begin @(negedge clk); n++; end
    check({name, "_down"}, 32'(kbd_bus.key_down), 32'(lvl));
  endtask

  task automatic read_key();
    @(negedge clk);
    kbd_bus.key_rd = 1'b1;
    @(negedge clk);
    kbd_bus.key_rd = 1'b0;
  endtask

  initial begin
    vecs[0] = '{row: 2, col: 1, exp_code: 4'd9,  exp_row_n: 4'b1011};
    vecs[1] = '{row: 1, col: 3, exp_code: 4'd7,  exp_row_n: 4'b1101};
    vecs[2] = '{row: 0, col: 0, exp_code: 4'd0,  exp_row_n: 4'b1110};
    vecs[3] = '{row: 3, col: 3, exp_code: 4'd15, exp_row_n: 4'b0111};
    vecs[4] = '{row: 1, col: 2, exp_code: 4'd6,  exp_row_n: 4'b1101};
    vecs[5] = '{row: 3, col: 0, exp_code: 4'd12, exp_row_n: 4'b0111};

    rst_n = 1'b0;
    keys = '0;
    kbd_bus.key_rd = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_row_n", 32'(row_n), 32'(4'b1110));
    check("rst_valid", 32'(kbd_bus.key_valid), 32'(0));
    check("rst_code", 32'(kbd_bus.key_code), 32'(0));
    check("rst_overrun", 32'(kbd_bus.overrun), 32'(0));
    check("rst_down", 32'(kbd_bus.key_down), 32'(0));
    rst_n = 1'b1;

    // Idle scan: each row dwells 4 cycles.
    for (int k = 1; k <= 16; k++) begin
      logic [3:0] exp_rn;
      @(posedge clk); #1;
      exp_rn = 4'b1111;
      exp_rn[(k / 4) % 4] = 1'b0;
      check("idle_row_n", 32'(row_n), 32'(exp_rn));
      check("idle_valid", 32'(kbd_bus.key_valid), 32'(0));
    end

    // Stable key (2,1): accept exactly 16 cycles after row 2 is entered, release 12 later.
    press_at_entry(2, 1, "hold");
    repeat (15) @(posedge clk); #1;
    check("hold_pre_valid", 32'(kbd_bus.key_valid), 32'(0));
    check("hold_pre_down", 32'(kbd_bus.key_down), 32'(0));
    @(posedge clk); #1;
    check("hold_valid", 32'(kbd_bus.key_valid), 32'(1));
    check("hold_down", 32'(kbd_bus.key_down), 32'(1));
    check("hold_code", 32'(kbd_bus.key_code), 32'(9));
    check("hold_row_frozen", 32'(row_n), 32'(4'b1011));
    keys = '0;
    repeat (11) @(posedge clk); #1;
    check("rel_pre_down", 32'(kbd_bus.key_down), 32'(1));
    check("rel_pre_row_n", 32'(row_n), 32'(4'b1011));
    @(posedge clk); #1;
    check("rel_down", 32'(kbd_bus.key_down), 32'(0));
    check("rel_row_n", 32'(row_n), 32'(4'b0111));
    check("rel_valid_kept", 32'(kbd_bus.key_valid), 32'(1));
    read_key();
    check("rd_valid_clr", 32'(kbd_bus.key_valid), 32'(0));

    // Bounce on (1,3): low for detect + one match, then open; no accept.
    press_at_entry(1, 3, "bounce");
    repeat (8) @(posedge clk); #1;
    check("bounce_row_frozen", 32'(row_n), 32'(4'b1101));
    keys = '0;
    repeat (4) @(posedge clk); #1;
    check("bounce_row_n", 32'(row_n), 32'(4'b1011));
    check("bounce_valid", 32'(kbd_bus.key_valid), 32'(0));
    check("bounce_down", 32'(kbd_bus.key_down), 32'(0));
    press_at_entry(1, 3, "bounce_stable");
    wait_valid("bounce_stable");
    check("bounce_stable_code", 32'(kbd_bus.key_code), 32'(7));
    keys = '0;
    wait_down(1'b0, "bounce_stable_rel");
    read_key();

    // Single-key table.
    foreach (vecs[i]) begin
      press_at_entry(vecs[i].row, vecs[i].col, "tbl");
      wait_valid("tbl");
      check("tbl_code", 32'(kbd_bus.key_code), 32'(vecs[i].exp_code));
      check("tbl_down", 32'(kbd_bus.key_down), 32'(1));
      check("tbl_row_n", 32'(row_n), 32'(vecs[i].exp_row_n));
      keys = '0;
      wait_down(1'b0, "tbl_rel");
      read_key();
      check("tbl_rd_valid", 32'(kbd_bus.key_valid), 32'(0));
    end

    // Overrun: second accept while the first code is unread.
    press_at_entry(0, 0, "ovr_first");
    wait_valid("ovr_first");
    check("ovr_first_code", 32'(kbd_bus.key_code), 32'(0));
    keys = '0;
    wait_down(1'b0, "ovr_first_rel");
    press_at_entry(3, 3, "ovr_second");
    wait_down(1'b1, "ovr_second");
    check("ovr_code_kept", 32'(kbd_bus.key_code), 32'(0));
    check("ovr_flag", 32'(kbd_bus.overrun), 32'(1));
    check("ovr_valid", 32'(kbd_bus.key_valid), 32'(1));
    keys = '0;
    wait_down(1'b0, "ovr_second_rel");
    read_key();
    check("ovr_rd_valid", 32'(kbd_bus.key_valid), 32'(0));
    check("ovr_rd_flag", 32'(kbd_bus.overrun), 32'(0));

    // Accept of code 5 on the same edge as key_rd for code 2.
    press_at_entry(0, 2, "coin_first");
    wait_valid("coin_first");
    check("coin_first_code", 32'(kbd_bus.key_code), 32'(2));
    keys[1*COLS+1] = 1'b1;
    keys[0*COLS+2] = 1'b0;
    begin
      int n = 0;
      while (row_n !== 4'b1101 && n < BUDGET) begin @(negedge clk); n++; end
      check("coin_row1_reached", 32'(row_n), 32'(4'b1101));
    end
    repeat (15) @(posedge clk); #1;
    check("coin_pre_code", 32'(kbd_bus.key_code), 32'(2));
    kbd_bus.key_rd = 1'b1;
    @(posedge clk); #1;
    kbd_bus.key_rd = 1'b0;
    check("coin_valid", 32'(kbd_bus.key_valid), 32'(1));
    check("coin_code", 32'(kbd_bus.key_code), 32'(5));
    check("coin_overrun", 32'(kbd_bus.overrun), 32'(0));
    keys = '0;
    wait_down(1'b0, "coin_rel");
    read_key();

    // Multiple keys, then reset while PRESSED; held keys are re-detected afterwards.
    begin
      int n = 0;
      while (row_n !== 4'b1110 && n < BUDGET) begin @(negedge clk); n++; end
      check("multi_row0_reached", 32'(row_n), 32'(4'b1110));
    end
    keys[1*COLS+2] = 1'b1;
    keys[1*COLS+0] = 1'b1;
    keys[3*COLS+0] = 1'b1;
    wait_valid("multi");
    check("multi_code", 32'(kbd_bus.key_code), 32'(4));
    check("multi_down", 32'(kbd_bus.key_down), 32'(1));
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mrst_row_n", 32'(row_n), 32'(4'b1110));
    check("mrst_valid", 32'(kbd_bus.key_valid), 32'(0));
    check("mrst_code", 32'(kbd_bus.key_code), 32'(0));
    check("mrst_down", 32'(kbd_bus.key_down), 32'(0));
    check("mrst_overrun", 32'(kbd_bus.overrun), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid("redetect");
    check("redetect_code", 32'(kbd_bus.key_code), 32'(4));
    keys = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
